// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with open-drain line enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic [1:0] err_code_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, DONE} state_t;
  state_t        state_q;
  logic [1:0]    clk_s_q, dat_s_q, code_q;
  logic          filt_q, clk_oe_q, data_oe_q, ready_q, busy_q, done_q, err_q, nack_q;
  logic [FW-1:0] fcnt_q;
  logic [IW-1:0] inh_q;
  logic [WW-1:0] wd_q, wd_d;
  logic [8:0]    sh_q;
  logic [3:0]    n_q, n_d;
  logic          flip, fall, timeout;
  assign flip    = (clk_s_q[1] != filt_q) && (fcnt_q == FW'(FILTER_CYCLES - 1));
  assign fall    = flip && filt_q;
  assign wd_d    = wd_q + 1'b1;
  assign n_d     = (n_q == 4'd11) ? n_q : n_q + 4'd1;
  assign timeout = (state_q inside {REQ, SHIFT, WAIT_IDLE}) && (wd_d == WW'(TIMEOUT_CYCLES));
  // synchronize both lines and debounce the clock: it only flips after a full run of stable samples
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk_i};
      dat_s_q <= {dat_s_q[0], ps2_data_i};
      if (clk_s_q[1] == filt_q) fcnt_q <= '0;
      else if (flip) begin
        filt_q <= clk_s_q[1];
        fcnt_q <= '0;
      end else fcnt_q <= fcnt_q + 1'b1;
    end
  // transfer sequencer: inhibit, request, clock out 8 data + parity + stop, collect ack, watchdog
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nack_q    <= 1'b0;
      code_q    <= 2'b00;
      sh_q      <= '0;
      n_q       <= '0;
      inh_q     <= '0;
      wd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q inside {REQ, SHIFT, WAIT_IDLE}) wd_q <= wd_d;
      if (timeout) begin
        state_q   <= DONE;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        done_q    <= 1'b1;
        err_q     <= 1'b1;
        code_q    <= 2'b01;
      end else
        case (state_q)
          IDLE:
            if (tx_valid_i) begin
              state_q  <= INHIBIT;
              sh_q     <= {~^tx_data_i, tx_data_i};
              code_q   <= 2'b00;
              n_q      <= '0;
              inh_q    <= '0;
              wd_q     <= '0;
              clk_oe_q <= 1'b1;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
            end
          INHIBIT: begin
            inh_q <= inh_q + 1'b1;
            if (inh_q == IW'(INHIBIT_CYCLES - 2)) data_oe_q <= 1'b1;
            if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
              clk_oe_q <= 1'b0;
              state_q  <= REQ;
            end
          end
          REQ: state_q <= SHIFT;
          SHIFT:
            if (fall) begin
              n_q <= n_d;
              if (n_d <= 4'd9) begin
                data_oe_q <= ~sh_q[0];
                sh_q      <= sh_q >> 1;
              end else if (n_d == 4'd10) data_oe_q <= 1'b0;
              else begin
                nack_q  <= dat_s_q[1];
                state_q <= WAIT_IDLE;
              end
            end
          WAIT_IDLE:
            if (filt_q && dat_s_q[1]) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= nack_q;
              code_q  <= nack_q ? 2'b10 : 2'b00;
            end
          DONE: begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
    end
  assign tx_ready_o    = ready_q;
  assign busy_o        = busy_q;
  assign tx_done_o     = done_q;
  assign tx_err_o      = err_q;
  assign err_code_o    = code_q;
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device model driven checks of the PS/2 host transmitter
module tb_ps2_host_tx;
  localparam int INH = 300;
  localparam int TMO = 5000;
  localparam int H   = 25;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_lo = 1'b0, dev_dat_lo = 1'b0, glitch_lo = 1'b0;
  logic       clk_line, data_line;
  int         total = 0, bad = 0;
  int         cyc = 0, hi_cnt = 0, last_hi = 0, t_req = 0, done_total = 0, exp_done = 0;
  logic       prev_clk_oe = 1'b0;
  assign clk_line  = ~(ps2_clk_oe | dev_clk_lo | glitch_lo);
  assign data_line = ~(ps2_data_oe | dev_dat_lo);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .busy_o(busy), .tx_done_o(tx_done), .tx_err_o(tx_err),
    .err_code_o(err_code), .ps2_clk_i(clk_line), .ps2_data_i(data_line),
    .ps2_clk_oe_o(ps2_clk_oe), .ps2_data_oe_o(ps2_data_oe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ps2_clk_oe) hi_cnt <= hi_cnt + 1;
    else if (hi_cnt != 0) begin
      last_hi <= hi_cnt;
      hi_cnt  <= 0;
    end
    if (prev_clk_oe && !ps2_clk_oe) t_req <= cyc;
    prev_clk_oe <= ps2_clk_oe;
    if (tx_done) done_total <= done_total + 1;
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d};
  endfunction
  task automatic device(input bit ack, input bit glitch, input int stop, output logic [9:0] bits, output bit req_ok);
    bits = '0;
    req_ok = 1'b0;
    for (int w = 0; w < INH + 100 && !req_ok; w++) begin
      @(negedge clk);
      req_ok = !ps2_clk_oe && ps2_data_oe;
    end
    if (!req_ok) return;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= stop; i++) begin
      dev_clk_lo = 1'b1;
      if (i == stop && stop < 11) begin
        repeat (15) @(negedge clk);
        return;
      end
      repeat (H) @(negedge clk);
      if (i <= 10) bits[i-1] = data_line;
      dev_clk_lo = 1'b0;
      if (i == 11) begin
        dev_dat_lo = 1'b0;
        return;
      end
      if (i == 10 && ack) dev_dat_lo = 1'b1;
      if (glitch) begin
        repeat (8) @(negedge clk);
        glitch_lo = 1'b1;
        repeat (3) @(negedge clk);
        glitch_lo = 1'b0;
        repeat (H - 11) @(negedge clk);
      end else repeat (H) @(negedge clk);
    end
  endtask
  task automatic wait_done(input int lim, output bit seen, output logic e, output logic [1:0] c, output int td);
    seen = 1'b0;
    e = 1'b0;
    c = 2'b00;
    td = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        e = tx_err;
        c = err_code;
        td = cyc;
        break;
      end
    end
  endtask
  task automatic check_idle(input string tag, input logic [1:0] code);
    repeat (3) @(negedge clk);
    chk({tag, "_idle"}, 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done}), 32'(5'b10000));
    chk({tag, "_code_held"}, 32'(err_code), 32'(code));
    chk({tag, "_done_count"}, 32'(done_total), 32'(exp_done));
  endtask
  task automatic run_xfer(input string tag, input logic [7:0] d, input bit ack, input bit glitch,
                          input logic exp_err, input logic [1:0] exp_code);
    logic [9:0] bits;
    bit rq, seen;
    logic e;
    logic [1:0] c;
    int td;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device(ack, glitch, 11, bits, rq);
    chk({tag, "_request"}, 32'(rq), 32'(1));
    chk({tag, "_bits"}, 32'(bits), 32'(frame(d)));
    wait_done(300, seen, e, c, td);
    exp_done++;
    chk({tag, "_done"}, 32'(seen), 32'(1));
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_errcode"}, 32'(c), 32'(exp_code));
    chk({tag, "_inhibit_len"}, 32'(last_hi), 32'(INH));
    check_idle(tag, exp_code);
  endtask
  typedef struct {
    logic [7:0] d;
    bit         ack;
    bit         glitch;
    logic       err;
    logic [1:0] code;
  } vec_t;
  vec_t tab[6];
  initial begin
    logic [9:0] bits;
    bit rq, seen;
    logic e;
    logic [1:0] c;
    int td;
    tab[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 2'b00};
    tab[1] = '{8'hF4, 1'b1, 1'b0, 1'b0, 2'b00};
    tab[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 2'b10};
    tab[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 2'b00};
    tab[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 2'b00};
    tab[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 2'b10};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({tx_ready, busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe}), 32'(8'b1000_0000));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++)
      run_xfer($sformatf("tab%0d", i), tab[i].d, tab[i].ack, tab[i].glitch, tab[i].err, tab[i].code);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      bit ack, gl;
      d = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      gl = 1'($urandom_range(0, 1));
      run_xfer($sformatf("rnd%0d", i), d, ack, gl, !ack, ack ? 2'b00 : 2'b10);
    end
    @(negedge clk);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done(TMO + INH + 100, seen, e, c, td);
    exp_done++;
    chk("tmo_done", 32'(seen), 32'(1));
    chk("tmo_latency", 32'(td - t_req), 32'(TMO));
    chk("tmo_err", 32'({e, c}), 32'(3'b101));
    check_idle("tmo", 2'b01);
    @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hAA;
    chk("hold_busy", 32'({busy, tx_ready}), 32'(2'b10));
    device(1'b1, 1'b0, 11, bits, rq);
    chk("hold_first_bits", 32'(bits), 32'(frame(8'hFF)));
    wait_done(300, seen, e, c, td);
    chk("hold_done", 32'({seen, e, c}), 32'(4'b1000));
    chk("hold_ready_at_done", 32'(tx_ready), 32'(0));
    @(negedge clk);
    chk("hold_ready_after", 32'(tx_ready), 32'(1));
    @(negedge clk);
    chk("hold_second_accept", 32'({ps2_clk_oe, busy, tx_ready}), 32'(3'b110));
    tx_valid = 1'b0;
    device(1'b1, 1'b0, 11, bits, rq);
    chk("hold_second_bits", 32'(bits), 32'(frame(8'hAA)));
    wait_done(300, seen, e, c, td);
    exp_done += 2;
    chk("hold_second_done", 32'({seen, e, c}), 32'(4'b1000));
    check_idle("hold", 2'b00);
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device(1'b1, 1'b0, 5, bits, rq);
    chk("rst_mid_busy_before", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_async", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done}), 32'(5'b00010));
    dev_clk_lo = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_total), 32'(exp_done));
    run_xfer("after_rst", 8'hED, 1'b1, 1'b0, 1'b0, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
